// File: rtl/seq_prime_pkg.sv
// Shared constants for the sequential prime detector.
// State encodings and per-divisor latency helper.
package seq_prime_pkg;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_CHECK = 3'd1;
   localparam state_t ST_DIV   = 3'd2;
   localparam state_t ST_TEST  = 3'd3;
   localparam state_t ST_DONE  = 3'd4;

   // launch + WIDTH remainder steps + test
   function automatic int div_latency(input int w);
      return w + 2;
   endfunction

endpackage

// File: rtl/seq_prime_detector_mod.sv
// Serial restoring remainder, one dividend bit per cycle.
// rem_valid pulses WIDTH cycles after start; rem holds until next start.
module mod_unit #(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic [WIDTH-1:0] rem,
   output logic             rem_valid
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [WIDTH-1:0] q;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] r_in;
   logic             b_in;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic [WIDTH-1:0] r_next;

   // first step is folded into the start cycle
   always_comb begin
      r_in    = start ? '0 : rem;
      b_in    = start ? dividend[WIDTH-1] : q[WIDTH-1];
      shifted = {r_in, b_in};
      diff    = shifted - {1'b0, divisor};
      r_next  = diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem       <= '0;
         q         <= '0;
         cnt       <= '0;
         rem_valid <= 1'b0;
      end else if (start) begin
         rem       <= r_next;
         q         <= {dividend[WIDTH-2:0], 1'b0};
         cnt       <= CW'(WIDTH - 1);
         rem_valid <= 1'b0;
      end else if (cnt != '0) begin
         rem       <= r_next;
         q         <= {q[WIDTH-2:0], 1'b0};
         cnt       <= cnt - CW'(1);
         rem_valid <= (cnt == CW'(1));
      end else begin
         rem_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/seq_prime_detector.sv
// Sequential prime detector: trial division by 2 and odd d up to sqrt(n).
// Reports primality and smallest prime factor on a start/done handshake.
module seq_prime_detector
   import seq_prime_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] n,
   output logic             busy,
   output logic             done,
   output logic             is_prime,
   output logic [WIDTH-1:0] factor
);

   state_t             state;
   logic [WIDTH-1:0]   n_r;
   logic [WIDTH-1:0]   d;
   logic [WIDTH-1:0]   d_next;
   logic [2*WIDTH-1:0] sq;
   logic               div_wait;
   logic               mod_start;
   logic [WIDTH-1:0]   rem;
   logic               rem_valid;

   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);
   assign mod_start = (state == ST_DIV) && !div_wait;
   assign d_next    = d + WIDTH'(2);
   // double-width square so the bound test never wraps
   assign sq = {{WIDTH{1'b0}}, d_next} * {{WIDTH{1'b0}}, d_next};

   mod_unit #(.WIDTH(WIDTH)) u_mod (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (mod_start),
      .dividend  (n_r),
      .divisor   (d),
      .rem       (rem),
      .rem_valid (rem_valid)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         n_r      <= '0;
         d        <= '0;
         div_wait <= 1'b0;
         is_prime <= 1'b0;
         factor   <= '0;
      end else begin
         case (state)
            ST_IDLE: if (start) begin
               n_r      <= n;
               is_prime <= 1'b0;
               factor   <= '0;
               state    <= ST_CHECK;
            end
            ST_CHECK: begin
               if (n_r < WIDTH'(2)) begin
                  state <= ST_DONE;
               end else if (n_r == WIDTH'(2) || n_r == WIDTH'(3)) begin
                  is_prime <= 1'b1;
                  state    <= ST_DONE;
               end else if (!n_r[0]) begin
                  factor <= WIDTH'(2);
                  state  <= ST_DONE;
               end else if (n_r == WIDTH'(5) || n_r == WIDTH'(7)) begin
                  is_prime <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  d     <= WIDTH'(3);
                  state <= ST_DIV;
               end
            end
            ST_DIV: begin
               div_wait <= !rem_valid;
               if (rem_valid) state <= ST_TEST;
            end
            ST_TEST: begin
               if (rem == '0) begin
                  factor <= d;
                  state  <= ST_DONE;
               end else if (sq > {{WIDTH{1'b0}}, n_r}) begin
                  is_prime <= 1'b1;
                  state    <= ST_DONE;
               end else begin
                  d     <= d_next;
                  state <= ST_DIV;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_seq_prime_detector.sv
// Directed bench for seq_prime_detector at WIDTH=8 and WIDTH=16.
// Cycle k is the period ending at edge k; edge 0 samples start.
module tb_seq_prime_detector;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s8, s16;
   logic [7:0]  n8, f8;
   logic [15:0] n16, f16;
   logic        busy8, done8, p8;
   logic        busy16, done16, p16;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   seq_prime_detector #(.WIDTH(8)) u_dut8 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (s8),
      .n        (n8),
      .busy     (busy8),
      .done     (done8),
      .is_prime (p8),
      .factor   (f8)
   );

   seq_prime_detector #(.WIDTH(16)) u_dut16 (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (s16),
      .n        (n16),
      .busy     (busy16),
      .done     (done16),
      .is_prime (p16),
      .factor   (f16)
   );

   task automatic check(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic run_op(input int w, input logic [31:0] v,
                         input logic ep, input logic [31:0] ef,
                         input int ecyc, input bit hold);
      int   cyc;
      int   extra;
      logic got, bsy1, bsyd, dn;
      string tag;
      tag = $sformatf("w%0d n=%0d", w, v);
      @(negedge clk);
      if (w == 8) begin s8 = 1'b1; n8 = v[7:0]; end
      else begin s16 = 1'b1; n16 = v[15:0]; end
      @(posedge clk);
      #1;
      if (hold) begin
         n8 = 8'd4;
         n16 = 16'd4;
      end else begin
         s8 = 1'b0;
         s16 = 1'b0;
      end
      cyc = 0;
      got = 1'b0;
      bsy1 = 1'b0;
      bsyd = 1'b0;
      while (cyc < 5000 && !got) begin
         @(negedge clk);
         cyc++;
         dn = (w == 8) ? done8 : done16;
         if (cyc == 1) bsy1 = (w == 8) ? busy8 : busy16;
         if (dn) begin
            got  = 1'b1;
            bsyd = (w == 8) ? busy8 : busy16;
         end
      end
      s8 = 1'b0;
      s16 = 1'b0;
      check({tag, " done seen"}, 32'(got), 32'd1);
      check({tag, " done cycle"}, 32'(cyc), 32'(ecyc));
      check({tag, " busy c1"}, 32'(bsy1), 32'd1);
      check({tag, " busy done"}, 32'(bsyd), 32'd1);
      check({tag, " is_prime"}, 32'(w == 8 ? p8 : p16), 32'(ep));
      check({tag, " factor"}, (w == 8) ? 32'(f8) : 32'(f16), ef);
      extra = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         if ((w == 8) ? done8 : done16) extra++;
      end
      check({tag, " extra done"}, 32'(extra), 32'd0);
      check({tag, " busy after"}, 32'(w == 8 ? busy8 : busy16), 32'd0);
      check({tag, " held prime"}, 32'(w == 8 ? p8 : p16), 32'(ep));
   endtask

   logic [15:0] sw_prime   = 16'b0010_1000_1010_1100;
   int          sw_fac[16] = '{0,0,0,0,2,0,2,0,2,3,2,0,2,0,2,3};
   int          sw_cyc[16] = '{2,2,2,2,2,2,2,2,2,12,2,12,2,12,2,12};

   initial begin
      int dcount;
      rst_n = 1'b0;
      s8 = 1'b0;
      s16 = 1'b0;
      n8 = '0;
      n16 = '0;
      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy8), 32'd0);
      check("reset done", 32'(done8), 32'd0);
      check("reset prime", 32'(p8), 32'd0);
      check("reset factor", 32'(f16), 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 16; i++)
         run_op(8, 32'(i), sw_prime[i], 32'(sw_fac[i]), sw_cyc[i], 1'b0);

      run_op(8, 9, 1'b0, 3, 12, 1'b0);
      run_op(8, 25, 1'b0, 5, 22, 1'b0);
      run_op(8, 251, 1'b1, 0, 72, 1'b0);
      run_op(8, 255, 1'b0, 3, 12, 1'b0);
      run_op(8, 49, 1'b0, 7, 32, 1'b0);
      run_op(16, 65521, 1'b1, 0, 2288, 1'b0);
      run_op(16, 65535, 1'b0, 3, 20, 1'b0);
      run_op(16, 10403, 1'b0, 101, 902, 1'b0);

      // start held every cycle while busy, n changed after accept
      run_op(8, 25, 1'b0, 5, 22, 1'b1);

      // async reset in the middle of trial division
      @(negedge clk);
      s8 = 1'b1;
      n8 = 8'd251;
      @(posedge clk);
      #1;
      s8 = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst busy", 32'(busy8), 32'd0);
      check("rst done", 32'(done8), 32'd0);
      check("rst prime", 32'(p8), 32'd0);
      check("rst factor", 32'(f8), 32'd0);
      dcount = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (done8) dcount++;
      end
      rst_n = 1'b1;
      for (int i = 0; i < 80; i++) begin
         @(negedge clk);
         if (done8) dcount++;
      end
      check("rst no done", 32'(dcount), 32'd0);
      run_op(8, 13, 1'b1, 0, 12, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
